// File: rtl/ascon_pkg.sv
// ascon_pkg -- shared types and helpers for the ASCON round controller.
//   ROUNDS_A_DEF / ROUNDS_B_DEF : default round counts for p^a / p^b
//   state_e                     : controller FSM states
//   round_const()               : ASCON round constant from remaining-rounds count
package ascon_pkg;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Constant for the round with r rounds remaining: {r+3, 12-r}, each nibble mod 16.
  // r=12 -> 0xF0, r=8 -> 0xB4, r=1 -> 0x4B.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = r + 4'd3;
    lo = 4'd12 - r;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ascon_down_counter.sv
// ascon_down_counter -- loadable saturating down counter.
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low, clears count
//   en_i       : counter update enable
//   load_i     : load load_val_i (wins over decrement when en_i high)
//   load_val_i : value to load
//   cnt_o      : current count
module ascon_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en_i) begin
      if (load_i)
        r_cnt <= load_val_i;
      else if (r_cnt != '0)   // saturate at zero, never wrap
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl -- sequences the rounds of an ASCON p^a / p^b permutation.
// Optional feature: define ASCON_ROUND_CTRL_ABORT_EN to add abort_i.
// Ports:
//   clk, rst                    : clock (rising), async active-high reset
//   start_valid_i/start_ready_o : permutation request handshake (ready only in IDLE)
//   rounds_sel_i                : 0 -> ROUNDS_A, 1 -> ROUNDS_B, sampled on start
//   round_en_o                  : apply one round this cycle
//   round_const_o               : round constant for current round (0 outside RUN)
//   round_idx_o                 : remaining rounds including current one
//   last_round_o                : current round is the final one
//   done_valid_o/done_ready_i   : completion handshake
//   busy_o                      : not IDLE
//   abort_i (optional)          : drop the current operation, return to IDLE
module ascon_round_ctrl
  import ascon_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ASCON_ROUND_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             rounds_sel_i,
  output logic             round_en_o,
  output logic [7:0]       round_const_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic             last_round_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic             busy_o
);

  state_e           r_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_sel_cnt;
  logic [CNT_W-1:0] w_load_val;
  logic             w_start_hs;
  logic             w_load;
  logic             w_en;
  logic             w_run;
  logic             w_last;

  assign w_run      = (r_state == S_RUN);
  assign w_start_hs = start_valid_i && (r_state == S_IDLE);
  assign w_sel_cnt  = rounds_sel_i ? CNT_W'(ROUNDS_B) : CNT_W'(ROUNDS_A);
  assign w_last     = w_run && (w_cnt == CNT_W'(1));

`ifdef ASCON_ROUND_CTRL_ABORT_EN
  logic w_abort;
  assign w_abort    = abort_i && (r_state != S_IDLE);
  // Abort reuses the load path to clear the counter in one cycle.
  assign w_load     = w_start_hs || w_abort;
  assign w_load_val = w_abort ? '0 : w_sel_cnt;
`else
  assign w_load     = w_start_hs;
  assign w_load_val = w_sel_cnt;
`endif

  assign w_en = w_load || w_run;

  ascon_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (!rst),
    .en_i       (w_en),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .cnt_o      (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
`endif
        case (r_state)
          S_IDLE:  if (start_valid_i) r_state <= S_RUN;
          S_RUN:   if (w_last)        r_state <= S_DONE;
          S_DONE:  if (done_ready_i)  r_state <= S_IDLE;
          default:                    r_state <= S_IDLE;
        endcase
`ifdef ASCON_ROUND_CTRL_ABORT_EN
      end
`endif
    end
  end

  // All outputs are pure decodes of the state and counter registers.
  assign start_ready_o = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_valid_o  = (r_state == S_DONE);
  assign round_en_o    = w_run;
  assign last_round_o  = w_last;
  assign round_idx_o   = w_cnt;
  assign round_const_o = w_run ? round_const(4'(w_cnt)) : 8'h00;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
module tb_ascon_round_ctrl;

  localparam int CNT_W = 4;
  localparam int RA    = 12;
  localparam int RB    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid_i = 1'b0;
  logic             start_ready_o;
  logic             rounds_sel_i = 1'b0;
  logic             round_en_o;
  logic [7:0]       round_const_o;
  logic [CNT_W-1:0] round_idx_o;
  logic             last_round_o;
  logic             done_valid_o;
  logic             done_ready_i = 1'b0;
  logic             busy_o;
`ifdef ASCON_ROUND_CTRL_ABORT_EN
  logic             abort_i = 1'b0;
`endif

  ascon_round_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef ASCON_ROUND_CTRL_ABORT_EN
    .abort_i       (abort_i),
`endif
    .start_valid_i (start_valid_i),
    .start_ready_o (start_ready_o),
    .rounds_sel_i  (rounds_sel_i),
    .round_en_o    (round_en_o),
    .round_const_o (round_const_o),
    .round_idx_o   (round_idx_o),
    .last_round_o  (last_round_o),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected round events, each stamped with the cycle it must appear in.
  typedef struct {
    int cyc;
    int idx;
    int rc;
    bit last;
  } rnd_t;
  rnd_t q[$];

  // Reference model state, expressed in cycle arithmetic.
  bit m_idle      = 1'b1;
  bit m_idle_next = 1'b1;
  int m_done_cyc  = 0;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string nm, input bit ok, input int act, input int exp_v);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp_v);
    end
  endfunction

  // Drop expected events at or after cycle lim.
  function automatic void flush(input int lim);
    rnd_t keep[$];
    foreach (q[i]) if (q[i].cyc < lim) keep.push_back(q[i]);
    q = keep;
  endfunction

  function automatic void push_op(input int t, input int r_tot);
    for (int i = 1; i <= r_tot; i++) begin
      rnd_t e;
      int r;
      r      = r_tot - i + 1;
      e.cyc  = t + i;
      e.idx  = r;
      e.rc   = (((r + 3) & 15) << 4) | ((12 - r) & 15);
      e.last = (r == 1);
      q.push_back(e);
    end
  endfunction

  // One cycle of stimulus; the model decides what the handshakes do.
  task automatic step(input bit sv, input bit sel, input bit dr, input bit ab);
    bit ab_eff;
    ab_eff = ab;
`ifndef ASCON_ROUND_CTRL_ABORT_EN
    ab_eff = 1'b0;
`endif
    @(posedge clk); #1;
    m_idle        = m_idle_next;
    start_valid_i = sv;
    rounds_sel_i  = sel;
    done_ready_i  = dr;
`ifdef ASCON_ROUND_CTRL_ABORT_EN
    abort_i       = ab_eff;
`endif
    m_idle_next = m_idle;
    if (ab_eff && !m_idle) begin
      flush(cyc + 1);
      m_idle_next = 1'b1;
    end else if (m_idle && sv) begin
      push_op(cyc, sel ? RB : RA);
      m_done_cyc  = cyc + (sel ? RB : RA) + 1;
      m_idle_next = 1'b0;
    end else if (!m_idle && cyc >= m_done_cyc && dr) begin
      m_idle_next = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst           = 1'b1;
    start_valid_i = 1'b0;
    done_ready_i  = 1'b0;
`ifdef ASCON_ROUND_CTRL_ABORT_EN
    abort_i       = 1'b0;
`endif
    flush(cyc);
    m_idle      = 1'b1;
    m_idle_next = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle on the falling edge.
  always @(negedge clk) begin
    check("start_ready", start_ready_o == m_idle, start_ready_o, m_idle);
    check("busy", busy_o == !m_idle, busy_o, !m_idle);
    check("done_valid", done_valid_o == (!m_idle && cyc >= m_done_cyc),
          done_valid_o, (!m_idle && cyc >= m_done_cyc));
    if (round_en_o) begin
      if (q.size() == 0) begin
        check("unexpected_round", 1'b0, round_idx_o, 0);
      end else begin
        rnd_t e;
        e = q.pop_front();
        check("round_cyc", e.cyc == cyc, cyc, e.cyc);
        check("round_idx", e.idx == int'(round_idx_o), round_idx_o, e.idx);
        check("round_const", e.rc == int'(round_const_o), round_const_o, e.rc);
        check("last_round", e.last == last_round_o, last_round_o, e.last);
      end
    end else begin
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        check("missing_round", 1'b0, 0, q[0].idx);
        void'(q.pop_front());
      end
      check("idle_outputs",
            round_const_o == 8'h00 && !last_round_o && round_idx_o == '0,
            {round_const_o, 3'b0, last_round_o, round_idx_o}, 0);
    end
  end

  initial begin
    // Reset held for a few cycles; monitor checks reset values meanwhile.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // p^a with consumer always ready.
    step(1, 0, 1, 0);
    repeat (16) step(0, 0, 1, 0);

    // p^b.
    step(1, 1, 1, 0);
    repeat (12) step(0, 0, 1, 0);

    // Consumer stalls; start requests during DONE must be ignored.
    step(1, 1, 0, 0);
    repeat (14) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // Reset during round 6 of p^a, then a clean run.
    step(1, 0, 1, 0);
    repeat (5) step(0, 0, 1, 0);
    do_reset();
    step(1, 0, 1, 0);
    repeat (16) step(0, 0, 1, 0);

`ifdef ASCON_ROUND_CTRL_ABORT_EN
    // Abort at round 3.
    step(1, 0, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 1, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    // Drain.
    repeat (20) step(0, 0, 1, 0);
    @(negedge clk);
    check("queue_empty", q.size() == 0, q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
ASCON_ROUND_CTRL -- requirements
Module: ascon_round_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the remaining-rounds counter.
REQ-002 SHALL have parameter ROUNDS_A, default 12: round count for the p^a permutation.
REQ-003 SHALL have parameter ROUNDS_B, default 8: round count for the p^b permutation.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start_valid_i, input, 1 bit: permutation request.
REQ-007 SHALL have port start_ready_o, output, 1 bit: request accepted when high together with start_valid_i.
REQ-008 SHALL have port rounds_sel_i, input, 1 bit: 0 selects ROUNDS_A, 1 selects ROUNDS_B; sampled on start handshake.
REQ-009 SHALL have port round_en_o, output, 1 bit: apply one round this cycle.
REQ-010 SHALL have port round_const_o, output, 8 bits: ASCON round constant for the current round.
REQ-011 SHALL have port round_idx_o, output, CNT_W bits: remaining rounds including the current one.
REQ-012 SHALL have port last_round_o, output, 1 bit: current round is the final round.
REQ-013 SHALL have port done_valid_o, output, 1 bit: permutation complete.
REQ-014 SHALL have port done_ready_i, input, 1 bit: consumer accepts completion.
REQ-015 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL assert start_ready_o only in IDLE.
REQ-018 SHALL, on the IDLE start handshake at cycle T, load the counter with the selected round count and enter RUN at T+1.
REQ-019 SHALL, in RUN, assert round_en_o every cycle and decrement the counter by 1 per cycle.
REQ-020 SHALL drive round_idx_o = r, the current counter value.
REQ-021 SHALL drive round_const_o = {(r+3) in 4 bits, (12-r) in 4 bits}: r=12 gives 0xF0, r=8 gives 0xB4, r=1 gives 0x4B.
REQ-022 SHALL assert last_round_o when in RUN and r==1, and SHALL move RUN to DONE on that cycle.
REQ-023 SHALL give a latency of: rounds on cycles T+1..T+R, done_valid_o first high at T+R+1.
REQ-024 SHALL hold done_valid_o high in DONE until done_ready_i is high, then enter IDLE on the next cycle.
REQ-025 SHALL ignore start_valid_i outside IDLE; the earliest next acceptance is the cycle after the done handshake.
REQ-026 SHALL drive round_en_o, last_round_o and round_const_o to 0 outside RUN.
REQ-027 SHALL never wrap the counter below zero; a load value of 0 is not reachable.

Reset
REQ-028 SHALL, while rst is high, force state IDLE and counter 0, asynchronously.
REQ-029 SHALL give these reset values: start_ready_o=1, busy_o=0, round_en_o=0, done_valid_o=0, last_round_o=0, round_const_o=0, round_idx_o=0.
REQ-030 SHALL, on rst mid-RUN or mid-DONE, discard the operation with no done_valid_o pulse.

Configuration
REQ-031 SHALL, with macro ASCON_ROUND_CTRL_ABORT_EN defined, add input abort_i (1 bit).
REQ-032 SHALL, with abort_i high in RUN or DONE, go to IDLE next cycle, clear the counter and emit no done.
REQ-033 SHALL let abort_i take priority over done_ready_i and the last-round transition.
REQ-034 SHALL, with the macro undefined, have no abort_i port and no abort logic.

Structure
REQ-035 SHALL take ROUNDS_A/ROUNDS_B defaults, the FSM state enum and the round-constant function from shared package ascon_pkg.
REQ-036 SHALL instantiate sub-module ascon_down_counter (WIDTH=CNT_W, rst_n = !rst) for the round counter.
REQ-037 SHALL drive the counter as: load_i from the start handshake or abort, en_i from load or RUN.

Verification
REQ-038 SHALL cover: start with rounds_sel_i=0 at cycle 0 -> round_en_o cycles 1..12, constants 0xF0..0x4B, done_valid_o at cycle 13.
REQ-039 SHALL cover: start with rounds_sel_i=1 -> 8 rounds, constants 0xB4..0x4B, last_round_o only with 0x4B.
REQ-040 SHALL cover: done_ready_i held low 5 cycles -> done_valid_o stays high; start_valid_i during DONE is not accepted.
REQ-041 SHALL cover: rst pulsed at round 6 of p^a -> all outputs at reset values immediately, no done; a new start runs cleanly.
REQ-042 SHALL cover: with ASCON_ROUND_CTRL_ABORT_EN, abort_i at round 3 -> IDLE next cycle, start_ready_o=1, no done_valid_o.
